// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: read ports, two write ports, scoreboard issue and trace PC.
// master drives addresses/writes/issue; slave is the register file.
interface regfile_mp_sb_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [DW-1:0]     wa_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [31:0]       trace_pc;
  logic              busy_any;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr, trace_pc,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr, trace_pc,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with write bypass and a busy-bit scoreboard.
// Optional write trace printing is enabled by defining REGFILE_TRACE_EN.
module regfile_mp_sb #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0]   mem_q [NREG] = '{default: '0};
  logic [NREG-1:0] busy_q, busy_d;
  logic            busy_any_q;
  logic            wa_eff, wb_eff, iss_eff;

  assign wa_eff  = bus.wa_en  && (!ZERO_REG || bus.wa_addr  != '0);
  assign wb_eff  = bus.wb_en  && (!ZERO_REG || bus.wb_addr  != '0);
  assign iss_eff = bus.iss_en && (!ZERO_REG || bus.iss_addr != '0);

  // Port B outranks port A on a same-address collision, both here and in storage.
  function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] a);
    if (ZERO_REG && a == '0)          return '0;
    if (wb_eff && bus.wb_addr == a)   return bus.wb_data;
    if (wa_eff && bus.wa_addr == a)   return bus.wa_data;
    return mem_q[a];
  endfunction

  // Data arriving by bypass this cycle is never reported as busy.
  function automatic logic rd_pending(input logic [AW-1:0] a);
    if (ZERO_REG && a == '0)                                  return 1'b0;
    if ((wb_eff && bus.wb_addr == a) || (wa_eff && bus.wa_addr == a)) return 1'b0;
    return busy_q[a];
  endfunction

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*DW +: DW] = rd_value(bus.rd_addr[k*AW +: AW]);
      bus.rd_busy[k]          = rd_pending(bus.rd_addr[k*AW +: AW]);
    end
  end

  // Issue is applied last so it wins over a same-cycle clear.
  always_comb begin
    busy_d = busy_q;
    if (wa_eff)  busy_d[bus.wa_addr]  = 1'b0;
    if (wb_eff)  busy_d[bus.wb_addr]  = 1'b0;
    if (iss_eff) busy_d[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      if (wa_eff) mem_q[bus.wa_addr] <= bus.wa_data;
      if (wb_eff) mem_q[bus.wb_addr] <= bus.wb_data;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
`ifdef REGFILE_TRACE_EN
      if (wa_eff && !(wb_eff && bus.wb_addr == bus.wa_addr))
        $display("@%h: $%d <= %h", bus.trace_pc, bus.wa_addr, bus.wa_data);
      if (wb_eff)
        $display("@%h: $%d <= %h", bus.trace_pc, bus.wb_addr, bus.wb_data);
`endif
    end
  end

`ifndef REGFILE_TRACE_EN
  logic unused_trace_pc;
  assign unused_trace_pc = ^bus.trace_pc;
`endif

  assign bus.busy_any = busy_any_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: expectations are queued when stimulus is driven
// and popped against the read ports / busy_any once outputs have settled.
module tb_regfile_mp_sb;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;

  typedef enum int {KData, KBusy, KAny} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  regfile_mp_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    bus.rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic push(input string tag, input kind_e kind, input int port, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.val = v;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #3;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        KData:   obs = bus.rd_data[e.port*DW +: DW];
        KBusy:   obs = {31'b0, bus.rd_busy[e.port]};
        default: obs = {31'b0, bus.busy_any};
      endcase
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    idle();
    bus.rd_addr  = '0;
    bus.trace_pc = 32'h0000_1000;

    // Reset, then sweep every address.
    tick(); tick();
    rst = 1'b0;
    push("reset_busy_any", KAny, 0, 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      set_rd(0, a); set_rd(1, a + 1);
      push($sformatf("reset_data_%0d", a),     KData, 0, 32'd0);
      push($sformatf("reset_data_%0d", a + 1), KData, 1, 32'd0);
      push($sformatf("reset_busy_%0d", a),     KBusy, 0, 32'd0);
      push($sformatf("reset_busy_%0d", a + 1), KBusy, 1, 32'd0);
      drain();
      tick();
    end

    // Port A write with same-cycle bypass, then read from storage.
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEAD_BEEF;
    set_rd(0, 5); set_rd(1, 6);
    push("wa_bypass_5", KData, 0, 32'hDEAD_BEEF);
    push("wa_bypass_6", KData, 1, 32'd0);
    drain(); tick(); idle();
    push("wa_stored_5", KData, 0, 32'hDEAD_BEEF);
    push("wa_nonbusy_5", KBusy, 0, 32'd0);
    drain(); tick();

    // Port B write to the top register, then hold.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 32'hCAFE_F00D;
    tick(); idle();
    set_rd(0, 31);
    push("wb_stored_31", KData, 0, 32'hCAFE_F00D);
    drain(); tick(); tick();
    push("wb_hold_31", KData, 0, 32'hCAFE_F00D);
    drain(); tick();

    // Collision: B wins in bypass and in storage.
    bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'd1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'd2;
    set_rd(1, 7);
    push("collide_bypass", KData, 1, 32'd2);
    drain(); tick(); idle();
    push("collide_stored", KData, 1, 32'd2);
    drain(); tick();

    // Register zero: writes and issue ignored.
    bus.wa_en = 1'b1; bus.wa_addr = '0; bus.wa_data = 32'h55;
    bus.wb_en = 1'b1; bus.wb_addr = '0; bus.wb_data = 32'h1234;
    bus.iss_en = 1'b1; bus.iss_addr = '0;
    set_rd(0, 0);
    push("zero_bypass", KData, 0, 32'd0);
    push("zero_busy_now", KBusy, 0, 32'd0);
    drain(); tick(); idle();
    push("zero_stored", KData, 0, 32'd0);
    push("zero_busy", KBusy, 0, 32'd0);
    push("zero_busy_any", KAny, 0, 32'd0);
    drain(); tick();

    // Scoreboard: issue, pending read, clearing write with bypass.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    tick(); idle();
    set_rd(0, 3);
    push("iss3_busy_any", KAny, 0, 32'd1);
    push("iss3_rd_busy", KBusy, 0, 32'd1);
    push("iss3_rd_data", KData, 0, 32'd0);
    drain();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'd9;
    push("wr3_rd_busy", KBusy, 0, 32'd0);
    push("wr3_rd_data", KData, 0, 32'd9);
    drain(); tick(); idle();
    push("clr3_rd_busy", KBusy, 0, 32'd0);
    push("clr3_rd_data", KData, 0, 32'd9);
    push("clr3_busy_any", KAny, 0, 32'd0);
    drain(); tick();

    // Issue beats a same-cycle write; re-issue does not count.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd4; bus.wa_data = 32'd44;
    set_rd(1, 4);
    push("iss4_wr_busy", KBusy, 1, 32'd0);
    push("iss4_wr_data", KData, 1, 32'd44);
    drain(); tick(); idle();
    push("iss4_busy", KBusy, 1, 32'd1);
    push("iss4_data", KData, 1, 32'd44);
    push("iss4_busy_any", KAny, 0, 32'd1);
    drain();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    tick(); idle();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'd77;
    push("wb4_bypass_busy", KBusy, 1, 32'd0);
    push("wb4_bypass_data", KData, 1, 32'd77);
    drain(); tick(); idle();
    push("wb4_cleared", KBusy, 1, 32'd0);
    push("wb4_busy_any", KAny, 0, 32'd0);
    drain(); tick();

    // Reset mid-operation drops a pending write and clears the scoreboard.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    tick();
    bus.iss_addr = 5'd8;
    tick(); idle();
    set_rd(0, 3); set_rd(1, 8);
    push("mid_busy3", KBusy, 0, 32'd1);
    push("mid_busy8", KBusy, 1, 32'd1);
    push("mid_busy_any", KAny, 0, 32'd1);
    drain();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hAAAA;
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    push("rst_busy3", KBusy, 0, 32'd0);
    push("rst_busy8", KBusy, 1, 32'd0);
    push("rst_data3", KData, 0, 32'd0);
    push("rst_busy_any", KAny, 0, 32'd0);
    drain(); tick();
    set_rd(0, 9); set_rd(1, 31);
    push("rst_dropped_9", KData, 0, 32'd0);
    push("rst_data31", KData, 1, 32'd0);
    drain(); tick();
    set_rd(0, 5); set_rd(1, 7);
    push("rst_data5", KData, 0, 32'd0);
    push("rst_data7", KData, 1, 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the CPU general register file.
- NRD combinational read ports, two synchronous write ports and an integrated busy-bit scoreboard.
- Sits in the decode and writeback stages: decode reads operands and checks hazards; writeback commits results through port A (ALU/M stage) or port B (memory/W stage).
- Same-cycle writes are forwarded to readers, so no half-cycle write/read trick is needed.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; register count NREG = 2**AW.
- NRD, 2, number of read ports; read buses are flattened, port k occupies slice [k*AW +: AW] / [k*DW +: DW].
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses.
- rd_data  out  NRD*DW  read data, combinational.
- rd_busy  out  NRD  scoreboard busy for each read address, combinational.
- wa_en  in  1  write port A enable.
- wa_addr  in  AW  write port A address.
- wa_data  in  DW  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  AW  write port B address.
- wb_data  in  DW  write port B data.
- iss_en  in  1  issue: mark destination pending.
- iss_addr  in  AW  destination being issued.
- trace_pc  in  32  PC of the writing instruction (used only with the trace feature).
- busy_any  out  1  OR of all busy bits, registered.

Behaviour:
- Storage: NREG x DW registers and NREG busy bits, all updated on posedge clk.
- Reset: rst high at a clock edge clears all registers to 0, clears all busy bits and sets busy_any = 0. Reset takes priority over writes and issue in that cycle. Registers are also initialised to 0 at time zero.
- Effective write: a port's write is effective when its enable is high and (ZERO_REG==0 or addr!=0).
- Write collision: wa_addr==wb_addr with both effective -> port B data is stored.
- Read priority for each read port k, highest first:
  - ZERO_REG && addr==0 -> 0;
  - effective write B to the same address -> wb_data;
  - effective write A to the same address -> wa_data;
  - else the stored value.
- Read latency: 0 cycles, purely combinational. A write at edge N is visible through storage from edge N onward and through bypass during cycle N-1.
- Scoreboard update at posedge clk, for each register r:
  - iss_en && iss_addr==r (and r!=0 when ZERO_REG) -> busy[r] set. Issue wins over a same-cycle clear.
  - else an effective write A or B to r -> busy[r] cleared.
  - else hold.
- Issuing to an already-busy register leaves it busy; there is no counting. Only one outstanding producer per register is allowed; the pipeline guarantees this.
- Writes to a non-busy register are legal: data is stored and the busy bit stays 0.
- rd_busy[k] = busy[rd_addr_k] AND NOT (an effective write to rd_addr_k this cycle), so data forwarded by bypass is never reported as busy. Forced 0 for address 0 when ZERO_REG.
- busy_any is registered: it is the OR of the next-state busy vector and becomes 0 in the cycle after reset.
- No X propagation: all outputs are defined whenever inputs are defined.

Optional Feature:
- Macro REGFILE_TRACE_EN.
- Defined: on each effective write at posedge clk when not in reset, $display("@%h: $%d <= %h", trace_pc, addr, data). Port A prints before port B. When both ports target the same address, only port B prints.
- Undefined: no display statements; trace_pc is ignored. Behaviour is otherwise identical.

Test Plan:
- Reset: pulse rst, read all 32 addresses -> every rd_data = 0, every rd_busy = 0, busy_any = 0.
- Write then read: wa_en=1, wa_addr=5, wa_data=32'hDEADBEEF for one edge; next cycle rd_addr0=5 -> rd_data0 = DEADBEEF. Same test on port B at address 31 -> 31 holds its value.
- Bypass and collision: in the same cycle wa_en=1 addr=7 data=1, wb_en=1 addr=7 data=2, rd_addr1=7 -> rd_data1 = 2 combinationally. After the edge, register 7 = 2.
- Zero register: wb_en=1, wb_addr=0, wb_data=32'h1234 and iss_en=1, iss_addr=0 -> rd_data for address 0 = 0, rd_busy = 0, busy_any stays 0.
- Scoreboard sequence:
  - iss addr 3 -> busy[3]=1, busy_any=1 next cycle.
  - Read addr 3 with no write -> rd_busy=1.
  - wa write addr 3 data 9 in the same cycle as the read -> rd_busy=0, rd_data=9.
  - After the edge busy[3]=0. Simultaneous iss and wa to addr 4 -> busy[4]=1.
- Reset mid-operation: busy bits for 3 and 8 set and wb write pending, assert rst -> after the edge all registers 0, busy_any 0, and the pending write is dropped.
